// File: rtl/motion_pkg.sv
// Motion detector shared definitions.
// State encoding and default parameter values.
package motion_pkg;

  localparam int          PERIOD_DEF   = 1000000;
  localparam int          TMO_DEF      = 4096;
  localparam logic [23:0] THRESH_DEF   = 24'h010000;
  localparam int          HITS_DEF     = 4;
  localparam int          CAL_LOG2_DEF = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_COLLECT = 3'd3;
  localparam logic [2:0] ST_EVAL    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WAIT    = ST_WAIT,
    FETCH   = ST_FETCH,
    COLLECT = ST_COLLECT,
    EVAL    = ST_EVAL
  } state_t;

endpackage

// File: rtl/motion_baseline.sv
// Calibration accumulator and baseline register.
// Ports: clk, rst_n, add/sample in; baseline, calibrated out.
module motion_baseline
  import motion_pkg::*;
#(
  parameter int CAL_LOG2 = CAL_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add,
  input  logic [23:0] sample,
  output logic [23:0] baseline,
  output logic        calibrated
);

  localparam int SW = 24 + CAL_LOG2;
  localparam int CW = CAL_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << CAL_LOG2) - 1);

  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_n;
  logic [CW-1:0] cnt_q;

  assign sum_n = sum_q + SW'(sample);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      baseline   <= '0;
      calibrated <= 1'b0;
    end else if (add && !calibrated) begin
      sum_q <= sum_n;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        baseline   <= 24'(sum_n >> CAL_LOG2);
        calibrated <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/motion_detector.sv
// Periodic accelerometer sampler with baseline calibration and hit alarm.
// Ports: clk, rst_n, enable, clear, acc_* handshake in/out; alarm, calibrated, sample_err, dev out.
module motion_detector
  import motion_pkg::*;
#(
  parameter int          PERIOD   = PERIOD_DEF,
  parameter int          TMO      = TMO_DEF,
  parameter logic [23:0] THRESH   = THRESH_DEF,
  parameter int          HITS     = HITS_DEF,
  parameter int          CAL_LOG2 = CAL_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        acc_ready,
  output logic        acc_fetch,
  input  logic        acc_arrived,
  input  logic [23:0] acc,
  output logic        alarm,
  output logic        calibrated,
  output logic        sample_err,
  output logic [23:0] dev
);

  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [3:0] HMAX = 4'(HITS);

  state_t      state_q;
  state_t      state_n;
  logic [PW-1:0] per_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]  hits_q;
  logic [3:0]  hits_n;
  logic [23:0] sample_q;
  logic [23:0] base;
  logic [23:0] dev_n;
  logic        timeout;
  logic        hit;
  logic        eval_run;
  logic        eval_cal;

  always_comb begin
    state_n   = state_q;
    acc_fetch = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: if (enable) state_n = WAIT;
      WAIT: begin
        if (!enable) state_n = IDLE;
        else if (per_q == '0) state_n = FETCH;
      end
      FETCH: begin
        if (acc_ready) begin
          acc_fetch = 1'b1;
          state_n   = COLLECT;
        end
      end
      COLLECT: begin
        if (acc_arrived) begin
          state_n = EVAL;
        end else if (tmo_q == TW'(TMO - 1)) begin
          timeout = 1'b1;
          state_n = WAIT;
        end
      end
      EVAL:    state_n = WAIT;
      default: state_n = IDLE;
    endcase
  end

  assign eval_cal = (state_q == EVAL) && !calibrated;
  assign eval_run = (state_q == EVAL) && calibrated;
  assign dev_n = (sample_q > base) ? sample_q - base : base - sample_q;
  assign hit = dev_n > THRESH;
  assign hits_n = !hit ? 4'd0 :
                  (hits_q == HMAX) ? hits_q : hits_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      per_q      <= '0;
      tmo_q      <= '0;
      hits_q     <= '0;
      sample_q   <= '0;
      dev        <= '0;
      alarm      <= 1'b0;
      sample_err <= 1'b0;
    end else begin
      state_q <= state_n;
      // The fetch cycle itself counts as PERIOD-1, so the register
      // continues from PERIOD-2 and fetches land PERIOD cycles apart.
      if (acc_fetch) per_q <= PW'(PERIOD - 2);
      else if (per_q != '0) per_q <= per_q - 1'b1;
      if (acc_fetch) tmo_q <= '0;
      else if (state_q == COLLECT) tmo_q <= tmo_q + 1'b1;
      if (state_q == COLLECT && acc_arrived) sample_q <= acc;
      if (eval_run) dev <= dev_n;
      if (clear) begin
        alarm      <= 1'b0;
        sample_err <= 1'b0;
        hits_q     <= '0;
      end else begin
        if (timeout) sample_err <= 1'b1;
        if (eval_run) begin
          hits_q <= hits_n;
          if (hits_n == HMAX) alarm <= 1'b1;
        end
      end
    end
  end

  motion_baseline #(
    .CAL_LOG2 (CAL_LOG2)
  ) u_base (
    .clk        (clk),
    .rst_n      (rst_n),
    .add        (eval_cal),
    .sample     (sample_q),
    .baseline   (base),
    .calibrated (calibrated)
  );

endmodule

// File: tb/tb_motion_detector.sv
// Directed bench for motion_detector.
// Small parameters; hand-computed expectations.
module tb_motion_detector;
  import motion_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        acc_ready = 1'b0;
  logic        acc_arrived = 1'b0;
  logic [23:0] acc = '0;
  logic        acc_fetch;
  logic        alarm;
  logic        calibrated;
  logic        sample_err;
  logic [23:0] dev;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int t[4];
  int tf;
  int pulses;

  motion_detector #(
    .PERIOD   (16),
    .TMO      (64),
    .THRESH   (24'd100),
    .HITS     (3),
    .CAL_LOG2 (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear       (clear),
    .acc_ready   (acc_ready),
    .acc_fetch   (acc_fetch),
    .acc_arrived (acc_arrived),
    .acc         (acc),
    .alarm       (alarm),
    .calibrated  (calibrated),
    .sample_err  (sample_err),
    .dev         (dev)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(output int tfo);
    tfo = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_fetch === 1'b1) begin
        tfo = cyc;
        break;
      end
    end
    if (tfo < 0) chk("fetch_wait", 32'd0, 32'd1);
  endtask

  task automatic sample(input logic [23:0] v, output int tfo);
    wait_fetch(tfo);
    @(negedge clk);
    acc_arrived = 1'b1;
    acc = v;
    @(negedge clk);
    acc_arrived = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_fetch", 32'(acc_fetch), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_cal", 32'(calibrated), 0);
    chk("rst_err", 32'(sample_err), 0);
    chk("rst_dev", 32'(dev), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    rst_n = 1'b1;
    enable = 1'b1;
    acc_ready = 1'b1;

    sample(24'd1000, t[0]);
    sample(24'd1000, t[1]);
    sample(24'd1000, t[2]);
    chk("cal_pending", 32'(calibrated), 0);
    sample(24'd1000, t[3]);
    chk("gap01", 32'(t[1] - t[0]), 16);
    chk("gap12", 32'(t[2] - t[1]), 16);
    chk("gap23", 32'(t[3] - t[2]), 16);
    chk("cal_done", 32'(calibrated), 1);
    chk("baseline", 32'(dut.u_base.baseline), 1000);
    chk("cal_alarm", 32'(alarm), 0);
    chk("cal_dev", 32'(dev), 0);

    sample(24'd1200, tf);
    chk("h1_dev", 32'(dev), 200);
    chk("h1_alarm", 32'(alarm), 0);
    sample(24'd1200, tf);
    chk("h2_dev", 32'(dev), 200);
    chk("h2_alarm", 32'(alarm), 0);
    sample(24'd1200, tf);
    chk("h3_dev", 32'(dev), 200);
    chk("h3_alarm", 32'(alarm), 1);
    chk("h3_hits", 32'(dut.hits_q), 3);
    sample(24'd1100, tf);
    chk("eq_dev", 32'(dev), 100);
    chk("eq_hits", 32'(dut.hits_q), 0);
    chk("eq_latched", 32'(alarm), 1);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_alarm", 32'(alarm), 0);
    chk("clr_cal", 32'(calibrated), 1);

    sample(24'd1200, tf);
    sample(24'd1200, tf);
    sample(24'd1050, tf);
    chk("brk_dev", 32'(dev), 50);
    chk("brk_hits", 32'(dut.hits_q), 0);
    sample(24'd1200, tf);
    sample(24'd1200, tf);
    chk("brk_alarm", 32'(alarm), 0);
    sample(24'd1200, tf);
    chk("brk_alarm3", 32'(alarm), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    sample(24'd1200, tf);
    sample(24'd1200, tf);
    chk("ce_hits2", 32'(dut.hits_q), 2);
    wait_fetch(tf);
    @(negedge clk);
    acc_arrived = 1'b1;
    acc = 24'd1200;
    @(negedge clk);
    acc_arrived = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("ce_alarm", 32'(alarm), 0);
    chk("ce_hits", 32'(dut.hits_q), 0);
    chk("ce_dev", 32'(dev), 200);
    @(negedge clk);
    chk("ce_alarm2", 32'(alarm), 0);

    sample(24'd1200, tf);
    chk("to_hits_pre", 32'(dut.hits_q), 1);
    acc_ready = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (acc_fetch === 1'b1) pulses++;
    end
    chk("nr_pulses", 32'(pulses), 0);
    chk("nr_state", 32'(dut.state_q), 32'(FETCH));
    acc_ready = 1'b1;
    #1;
    chk("nr_fetch", 32'(acc_fetch), 1);
    @(negedge clk);
    chk("nr_single", 32'(acc_fetch), 0);
    repeat (63) @(negedge clk);
    chk("to_err_pre", 32'(sample_err), 0);
    chk("to_state_pre", 32'(dut.state_q), 32'(COLLECT));
    @(negedge clk);
    chk("to_err", 32'(sample_err), 1);
    chk("to_state", 32'(dut.state_q), 32'(WAIT));
    chk("to_hits", 32'(dut.hits_q), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("to_clr", 32'(sample_err), 0);

    wait_fetch(tf);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_fetch", 32'(acc_fetch), 0);
    chk("mr_alarm", 32'(alarm), 0);
    chk("mr_cal", 32'(calibrated), 0);
    chk("mr_err", 32'(sample_err), 0);
    chk("mr_dev", 32'(dev), 0);
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    enable = 1'b0;
    acc_arrived = 1'b1;
    acc = 24'd5000;
    @(negedge clk);
    acc_arrived = 1'b0;
    @(negedge clk);
    chk("late_state", 32'(dut.state_q), 32'(IDLE));
    chk("late_sample", 32'(dut.sample_q), 0);
    chk("late_dev", 32'(dev), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_detector.md
MOTION_DETECTOR -- requirements
Module: motion_detector

Interface
REQ-001 Parameter PERIOD, default 1000000: Clock cycles between successive acc_fetch pulses; legal range >= 2.
REQ-002 Parameter TMO, default 4096: maximum cycles from acc_fetch to acc_arrived before a sample is abandoned.
REQ-003 Parameter THRESH, default 24'h010000: deviation above which a sample counts as a hit.
REQ-004 Parameter HITS, default 4: consecutive hits that raise alarm; legal range 1..15.
REQ-005 Parameter CAL_LOG2, default 3: baseline is averaged over 2^CAL_LOG2 samples.
REQ-006 Clock  in  1: single clock; all state changes occur on its rising edge.
REQ-007 Reset  in  1: synchronous, active-low reset.
REQ-008 enable  in  1: high permits sampling.
REQ-009 clear  in  1: one-cycle request that clears alarm, sample_err and hit count.
REQ-010 acc_ready  in  1: accelerometer front end is idle and accepts a fetch.
REQ-011 acc_fetch  out  1: one-cycle request for a new magnitude sample.
REQ-012 acc_arrived  in  1: one-cycle strobe; acc is valid in that same cycle.
REQ-013 acc  in  24: sum of squared axis values, unsigned.
REQ-014 alarm  out  1: latched motion alarm.
REQ-015 calibrated  out  1: baseline is valid.
REQ-016 sample_err  out  1: sticky flag set by a fetch timeout.
REQ-017 dev  out  24: absolute deviation of the last evaluated sample.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, FETCH, COLLECT and EVAL.
REQ-019 IDLE->WAIT when enable=1; WAIT->IDLE when enable=0; enable is ignored in FETCH, COLLECT and EVAL.
REQ-020 Period counter: loaded with PERIOD-1 in the cycle acc_fetch=1, then decrements and holds at 0; WAIT->FETCH when counter=0 and enable=1.
REQ-021 In FETCH, acc_fetch=1 for exactly one cycle in the first cycle acc_ready=1, then ->COLLECT; while acc_ready=0, stay in FETCH with acc_fetch=0.
REQ-022 In COLLECT: on acc_arrived, capture acc and ->EVAL.
REQ-023 Timeout: after TMO cycles in COLLECT without acc_arrived, set sample_err, discard the sample, ->WAIT; the hit count is unchanged.
REQ-024 acc_arrived outside COLLECT SHALL be ignored.
REQ-025 EVAL lasts one cycle, then ->WAIT.
REQ-026 Calibration: while calibrated=0, EVAL adds the captured acc to a (24+CAL_LOG2)-bit sum and does no hit evaluation.
REQ-027 On the 2^CAL_LOG2-th calibration sample, baseline = sum >> CAL_LOG2 (truncating) and calibrated=1 in the next cycle.
REQ-028 Evaluation: while calibrated=1, dev = |acc - baseline| computed without wrap; a hit is dev > THRESH (strict).
REQ-029 Hit counter: increments on a hit, saturating at HITS, and resets to 0 on a non-hit.
REQ-030 alarm SHALL set in the cycle after the hit counter reaches HITS and stay set until clear or Reset.
REQ-031 clear clears alarm, sample_err and the hit counter in the next cycle and does not touch baseline or calibrated.
REQ-032 If clear coincides with an alarm-setting EVAL, clear wins: alarm=0 and hit count=0.
REQ-033 If clear coincides with a timeout, clear wins: sample_err=0.

Reset
REQ-034 With Reset=0 at a rising Clock edge: state=IDLE, acc_fetch=0, alarm=0, calibrated=0, sample_err=0, dev=0, and the sum, baseline, hit counter and both counters are 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction; a late acc_arrived after reset is ignored per REQ-024.

Structure
REQ-036 Package motion_pkg SHALL hold the state encoding localparams and the default parameter values.
REQ-037 The calibration accumulator and baseline register SHALL be the single sub-module motion_baseline.

Verification
REQ-038 Use PERIOD=16, TMO=64, THRESH=100, HITS=3, CAL_LOG2=2.
REQ-039 Four samples of acc=1000 -> calibrated=1, baseline=1000, alarm=0, acc_fetch pulses exactly 16 cycles apart.
REQ-040 Calibrated, then acc=1200,1200,1200 -> dev=200 each, alarm=1 after the third EVAL; acc=1100 (dev=100) -> no hit.
REQ-041 Hits 1200,1200, then 1050, then 1200,1200 -> alarm=0; a third consecutive 1200 -> alarm=1.
REQ-042 acc_ready held 0 for 20 cycles -> acc_fetch stays 0, then one pulse when acc_ready=1; no acc_arrived for 64 cycles -> sample_err=1 and FSM in WAIT.
REQ-043 clear in the same cycle as the alarm-setting EVAL -> alarm=0 and hit count=0; Reset=0 during COLLECT -> all outputs zero next cycle and a late acc_arrived is ignored.
